// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster scan-out stage for the dual-write frame buffer.
//
// Generates VGA timing from the pixel clock. It drives the frame-buffer read
// address and expands the 8-bit RRRGGGBB pixel (returned one clk after its
// address) to 8/8/8 RGB. Sync, blank and colour all leave the block with the
// same 2-clk latency from the counter state, so they stay exactly aligned.
//
// Ports:
//   clk          pixel clock (also the frame buffer's clk_read)
//   reset        asynchronous, active-high
//   r_x_address  frame-buffer read column (0 outside the visible region)
//   r_y_address  frame-buffer read row    (0 outside the visible region)
//   pixel_in     frame-buffer data_out, RRRGGGBB, valid 1 clk after address
//   vga_r/g/b    DAC colour, forced to 0 while blanked
//   vga_hs/vs    sync, active-low
//   vga_blank_n  high during visible pixels
//   vga_sync_n   tied 0
//   frame_start  one-clk pulse after the counter state h=0,v=0
//   vblank       high while the vertical counter is outside the active region
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] r_x_address,
   output logic [9:0] r_y_address,
   input  logic [7:0] pixel_in,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_sync_n,
   output logic       frame_start,
   output logic       vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   // ---------------- stage 0: raster counters ----------------
   logic [9:0] h_cnt, v_cnt;
   logic       h_last, active;

   assign h_last = (h_cnt == H_LAST);
   assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   // Parking the address at 0,0 during blanking keeps the read bus quiet.
   assign r_x_address = active ? h_cnt : '0;
   assign r_y_address = active ? v_cnt : '0;

   // ---------------- stage 1: align controls with pixel_in ----------------
   logic active_d, hs_d, vs_d;
   logic hs_raw_n, vs_raw_n;

   assign hs_raw_n = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
   assign vs_raw_n = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_d    <= 1'b0;
         hs_d        <= 1'b1;
         vs_d        <= 1'b1;
         frame_start <= 1'b0;
         vblank      <= 1'b0;
      end else begin
         active_d    <= active;
         hs_d        <= hs_raw_n;
         vs_d        <= vs_raw_n;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         vblank      <= (v_cnt >= V_VIS);
      end
   end

   // ---------------- stage 2: DAC output registers ----------------
   // Colour expansion replicates the field MSBs so full-scale maps to 0xFF.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
      end else begin
         vga_hs      <= hs_d;
         vga_vs      <= vs_d;
         vga_blank_n <= active_d;
         if (active_d) begin
            vga_r <= {pixel_in[7:5], pixel_in[7:5], pixel_in[7:6]};
            vga_g <= {pixel_in[4:2], pixel_in[4:2], pixel_in[4:3]};
            vga_b <= {4{pixel_in[1:0]}};
         end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
         end
      end
   end

   assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: self-checking bench for vga_scanout.
//
// Two instances share the clock. u_small uses a shrunken raster (30x19) so
// whole frames and mid-frame resets fit a short run, and it reads a random
// frame buffer. u_full uses the real 640x480 timing and an x^y buffer, and it
// runs through the first lines without interruption. Expected outputs come
// from a reference model. The model derives the raster position directly from
// the clock count since reset with div/mod and applies the 2-clk output latency.
module tb_vga_scanout;

   localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
   localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;
   localparam int SFT = SHT * SVT;

   typedef struct {
      int x, y, r, g, b, hs, vs, bl, fs, vb;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, reset_full;
   logic [9:0] rx_s, ry_s, rx_f, ry_f;
   logic [7:0] pix_s = '0, pix_f = '0;
   logic [7:0] r_s, g_s, b_s, r_f, g_f, b_f;
   logic       hs_s, vs_s, bl_s, sn_s, fs_s, vb_s;
   logic       hs_f, vs_f, bl_f, sn_f, fs_f, vb_f;

   logic [7:0] fb [SVA][SHA];

   int n_chk = 0, n_fail = 0;
   int t = 0, tf = 0;
   bit win = 1'b0;
   int hs_lo = 0, vs_lo = 0, bl_hi = 0, fs_cnt = 0, vb_hi = 0;
   int f_hs_cnt = 0, f_hs_first = -1;

   always #5 clk = ~clk;

   vga_scanout #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) u_small (
      .clk(clk), .reset(reset),
      .r_x_address(rx_s), .r_y_address(ry_s), .pixel_in(pix_s),
      .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
      .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bl_s), .vga_sync_n(sn_s),
      .frame_start(fs_s), .vblank(vb_s)
   );

   vga_scanout u_full (
      .clk(clk), .reset(reset_full),
      .r_x_address(rx_f), .r_y_address(ry_f), .pixel_in(pix_f),
      .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
      .vga_hs(hs_f), .vga_vs(vs_f), .vga_blank_n(bl_f), .vga_sync_n(sn_f),
      .frame_start(fs_f), .vblank(vb_f)
   );

   // Frame-buffer models: synchronous read, data one clk after the address.
   always @(posedge clk) begin
      pix_s <= fb[ry_s][rx_s];
      pix_f <= rx_f[7:0] ^ ry_f[7:0];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t t=%0d tf=%0d got=%0h exp=%0h", tag, $time, t, tf, got, exp);
      end
   endtask

   function automatic exp_t model(input int tc, input bit full, input bit rst);
      int ht, vt, ha, va, hsb, hse, vsb, vse;
      int h, v, h1, v1, h2, v2, p, c3;
      exp_t e;
      ha  = full ? 640 : SHA;
      va  = full ? 480 : SVA;
      ht  = full ? 800 : SHT;
      vt  = full ? 525 : SVT;
      hsb = full ? 656 : SHA + SHF;
      hse = full ? 752 : SHA + SHF + SHS;
      vsb = full ? 490 : SVA + SVF;
      vse = full ? 492 : SVA + SVF + SVS;
      e.x = 0; e.y = 0; e.r = 0; e.g = 0; e.b = 0;
      e.hs = 1; e.vs = 1; e.bl = 0; e.fs = 0; e.vb = 0;
      if (rst) return e;
      h = tc % ht;
      v = (tc / ht) % vt;
      if (h < ha && v < va) begin
         e.x = h;
         e.y = v;
      end
      if (tc >= 1) begin
         h1 = (tc - 1) % ht;
         v1 = ((tc - 1) / ht) % vt;
         e.fs = (h1 == 0 && v1 == 0) ? 1 : 0;
         e.vb = (v1 >= va) ? 1 : 0;
      end
      if (tc >= 2) begin
         h2 = (tc - 2) % ht;
         v2 = ((tc - 2) / ht) % vt;
         e.hs = (h2 >= hsb && h2 < hse) ? 0 : 1;
         e.vs = (v2 >= vsb && v2 < vse) ? 0 : 1;
         if (h2 < ha && v2 < va) begin
            e.bl = 1;
            p = full ? ((h2 ^ v2) & 255) : int'(fb[v2][h2]);
            c3 = p >> 5;
            e.r = (c3 << 5) | (c3 << 2) | (c3 >> 1);
            c3 = (p >> 2) & 7;
            e.g = (c3 << 5) | (c3 << 2) | (c3 >> 1);
            e.b = (p & 3) * 8'h55;
         end
      end
      return e;
   endfunction

   task automatic cmp_small(input bit rst);
      exp_t e;
      e = model(t, 1'b0, rst);
      chk("s_xaddr", 32'(rx_s), e.x);
      chk("s_yaddr", 32'(ry_s), e.y);
      chk("s_r", 32'(r_s), e.r);
      chk("s_g", 32'(g_s), e.g);
      chk("s_b", 32'(b_s), e.b);
      chk("s_hs", 32'(hs_s), e.hs);
      chk("s_vs", 32'(vs_s), e.vs);
      chk("s_blank_n", 32'(bl_s), e.bl);
      chk("s_sync_n", 32'(sn_s), 0);
      chk("s_frame_start", 32'(fs_s), e.fs);
      chk("s_vblank", 32'(vb_s), e.vb);
      if (win && !rst) begin
         if (t >= 2 && t < 2 + 2 * SFT) begin
            hs_lo += int'(!hs_s);
            vs_lo += int'(!vs_s);
            bl_hi += int'(bl_s);
         end
         if (t >= 1 && t < 1 + 2 * SFT) begin
            fs_cnt += int'(fs_s);
            vb_hi  += int'(vb_s);
         end
         // last visible pixel forced to 0xFF, then the first blanked clk
         if (t == (SVA - 1) * SHT + (SHA - 1) + 2)
            chk("s_last_pix_rgb", {8'h0, r_s, g_s, b_s}, 32'hFFFFFF);
         if (t == (SVA - 1) * SHT + SHA + 2)
            chk("s_after_last_blank", {23'h0, bl_s, r_s, g_s, b_s}, 32'h0);
         if (t == 2 * SHT + 3 + 2)
            chk("s_pix_3_2_rgb", {8'h0, r_s, g_s, b_s}, 32'h000055);
      end
   endtask

   task automatic cmp_full();
      exp_t e;
      e = model(tf, 1'b1, 1'b0);
      chk("f_xaddr", 32'(rx_f), e.x);
      chk("f_yaddr", 32'(ry_f), e.y);
      chk("f_rgb", {8'h0, r_f, g_f, b_f}, (e.r << 16) | (e.g << 8) | e.b);
      chk("f_hs", 32'(hs_f), e.hs);
      chk("f_vs", 32'(vs_f), e.vs);
      chk("f_blank_n", 32'(bl_f), e.bl);
      chk("f_frame_start", 32'(fs_f), e.fs);
      chk("f_vblank", 32'(vb_f), e.vb);
      if (tf >= 2 && tf < 802 && !hs_f) begin
         f_hs_cnt++;
         if (f_hs_first < 0) f_hs_first = tf;
      end
      if (tf == 2 * 800 + 3 + 2)
         chk("f_pix_3_2_rgb", {8'h0, r_f, g_f, b_f}, 32'h000055);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         t++;
         tf++;
         @(negedge clk);
         cmp_small(1'b0);
         cmp_full();
      end
   endtask

   initial begin
      for (int y = 0; y < SVA; y++)
         for (int x = 0; x < SHA; x++)
            fb[y][x] = 8'($urandom);
      fb[2][3]             = 8'h01;
      fb[SVA - 1][SHA - 1] = 8'hFF;

      reset      = 1'b1;
      reset_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmp_small(1'b1);
         chk("f_reset_xy", {12'h0, rx_f, ry_f}, 32'h0);
         chk("f_reset_ctl", {26'h0, hs_f, vs_f, bl_f, fs_f, vb_f, sn_f}, 32'b110000);
         chk("f_reset_rgb", {8'h0, r_f, g_f, b_f}, 32'h0);
      end

      // release at a negedge: the cycle before the next posedge is t=0
      reset      = 1'b0;
      reset_full = 1'b0;
      t   = 0;
      tf  = 0;
      win = 1'b1;
      cmp_small(1'b0);
      cmp_full();
      cyc(2 * SFT + 660);
      win = 1'b0;

      chk("s_hs_low_2frames", hs_lo, 2 * SVT * SHS);
      chk("s_vs_low_2frames", vs_lo, 2 * SVS * SHT);
      chk("s_blank_hi_2frames", bl_hi, 2 * SHA * SVA);
      chk("s_frame_start_2frames", fs_cnt, 2);
      chk("s_vblank_hi_2frames", vb_hi, 2 * (SVT - SVA) * SHT);
      chk("f_hs_first_low", f_hs_first, 658);
      chk("f_hs_width", f_hs_cnt, 96);

      // mid-frame resets at random raster positions
      for (int k = 0; k < 3; k++) begin
         cyc(int'($urandom_range(40, 700)));
         #2 reset = 1'b1;
         #1 cmp_small(1'b1);        // asynchronous clear, before any edge
         @(posedge clk);
         tf++;
         @(negedge clk);
         cmp_small(1'b1);
         cmp_full();
         reset = 1'b0;
         t = 0;
         cmp_small(1'b0);
         cyc(3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
